// File: rtl/alu_reservation_station.sv
// Reservation station for ALU-class instructions: buffers dispatched ops, snoops both CDBs
// for operand wakeup, and issues the lowest-index ready entry to the ALU once per cycle.
module alu_reservation_station #(
   parameter int RS_SIZE    = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int OP_WIDTH   = 6,
   parameter int ROB_WIDTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  en_dsp_in,
   input  logic [ADDR_WIDTH-1:0] pc_dsp_in,
   input  logic [OP_WIDTH-1:0]   opcode_dsp_in,
   input  logic [DATA_WIDTH-1:0] imm_dsp_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_dsp_in,
   input  logic [DATA_WIDTH-1:0] vj_dsp_in,
   input  logic [DATA_WIDTH-1:0] vk_dsp_in,
   input  logic [ROB_WIDTH-1:0]  qj_dsp_in,
   input  logic [ROB_WIDTH-1:0]  qk_dsp_in,
   input  logic                  qj_busy_dsp_in,
   input  logic                  qk_busy_dsp_in,
   output logic                  full_dsp_out,
   input  logic                  rdy_a_cdb_in,
   input  logic [DATA_WIDTH-1:0] result_a_cdb_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_a_cdb_in,
   input  logic                  rdy_l_cdb_in,
   input  logic [DATA_WIDTH-1:0] result_l_cdb_in,
   input  logic [ROB_WIDTH-1:0]  rob_id_l_cdb_in,
   input  logic                  idle_alu_in,
   output logic                  rdy_alu_out,
   output logic [ADDR_WIDTH-1:0] pc_alu_out,
   output logic [OP_WIDTH-1:0]   opcode_alu_out,
   output logic [DATA_WIDTH-1:0] vj_alu_out,
   output logic [DATA_WIDTH-1:0] vk_alu_out,
   output logic [DATA_WIDTH-1:0] imm_alu_out,
   output logic [ROB_WIDTH-1:0]  rob_id_alu_out
);

   localparam int IDX_W = $clog2(RS_SIZE);
   localparam int CNT_W = $clog2(RS_SIZE) + 1;

   logic [RS_SIZE-1:0]    busy_reg, rj_reg, rk_reg;
   logic [ADDR_WIDTH-1:0] pc_reg  [RS_SIZE];
   logic [OP_WIDTH-1:0]   op_reg  [RS_SIZE];
   logic [DATA_WIDTH-1:0] imm_reg [RS_SIZE];
   logic [DATA_WIDTH-1:0] vj_reg  [RS_SIZE];
   logic [DATA_WIDTH-1:0] vk_reg  [RS_SIZE];
   logic [ROB_WIDTH-1:0]  rob_reg [RS_SIZE];
   logic [ROB_WIDTH-1:0]  qj_reg  [RS_SIZE];
   logic [ROB_WIDTH-1:0]  qk_reg  [RS_SIZE];
   logic [CNT_W-1:0]      count_reg, count_next;
   logic                  full_reg;

   logic                  iss_valid_reg;
   logic [ADDR_WIDTH-1:0] iss_pc_reg;
   logic [OP_WIDTH-1:0]   iss_op_reg;
   logic [DATA_WIDTH-1:0] iss_vj_reg, iss_vk_reg, iss_imm_reg;
   logic [ROB_WIDTH-1:0]  iss_rob_reg;

   logic [RS_SIZE-1:0]    ready_vec, wj_a, wj_l, wk_a, wk_l;
   logic [IDX_W-1:0]      free_idx, sel_idx;
   logic                  free_found, sel_found, do_dsp, do_iss;
   logic [DATA_WIDTH-1:0] dsp_vj, dsp_vk;
   logic                  dsp_rj, dsp_rk;

   genvar gi;
   generate
      for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
         assign ready_vec[gi] = busy_reg[gi] & ~rj_reg[gi] & ~rk_reg[gi];
         assign wj_a[gi] = busy_reg[gi] & rj_reg[gi] & rdy_a_cdb_in & (qj_reg[gi] == rob_id_a_cdb_in);
         assign wj_l[gi] = busy_reg[gi] & rj_reg[gi] & rdy_l_cdb_in & (qj_reg[gi] == rob_id_l_cdb_in);
         assign wk_a[gi] = busy_reg[gi] & rk_reg[gi] & rdy_a_cdb_in & (qk_reg[gi] == rob_id_a_cdb_in);
         assign wk_l[gi] = busy_reg[gi] & rk_reg[gi] & rdy_l_cdb_in & (qk_reg[gi] == rob_id_l_cdb_in);
      end
   endgenerate

   // Downward scan so the lowest matching index is the last one assigned.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_reg[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ready_vec[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // A tag being broadcast in the dispatch cycle is captured straight into the new entry.
   always_comb begin
      dsp_vj = vj_dsp_in;
      dsp_rj = qj_busy_dsp_in;
      if (qj_busy_dsp_in) begin
         if (rdy_a_cdb_in && rob_id_a_cdb_in == qj_dsp_in) begin
            dsp_vj = result_a_cdb_in;
            dsp_rj = 1'b0;
         end else if (rdy_l_cdb_in && rob_id_l_cdb_in == qj_dsp_in) begin
            dsp_vj = result_l_cdb_in;
            dsp_rj = 1'b0;
         end
      end
      dsp_vk = vk_dsp_in;
      dsp_rk = qk_busy_dsp_in;
      if (qk_busy_dsp_in) begin
         if (rdy_a_cdb_in && rob_id_a_cdb_in == qk_dsp_in) begin
            dsp_vk = result_a_cdb_in;
            dsp_rk = 1'b0;
         end else if (rdy_l_cdb_in && rob_id_l_cdb_in == qk_dsp_in) begin
            dsp_vk = result_l_cdb_in;
            dsp_rk = 1'b0;
         end
      end
   end

   assign do_dsp     = rdy_in & ~clear_in & en_dsp_in & ~full_reg & free_found;
   assign do_iss     = rdy_in & ~clear_in & idle_alu_in & sel_found;
   assign count_next = count_reg + CNT_W'(do_dsp) - CNT_W'(do_iss);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_reg      <= '0;
         rj_reg        <= '0;
         rk_reg        <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         iss_valid_reg <= 1'b0;
         iss_pc_reg    <= '0;
         iss_op_reg    <= '0;
         iss_vj_reg    <= '0;
         iss_vk_reg    <= '0;
         iss_imm_reg   <= '0;
         iss_rob_reg   <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            pc_reg[i]  <= '0;
            op_reg[i]  <= '0;
            imm_reg[i] <= '0;
            vj_reg[i]  <= '0;
            vk_reg[i]  <= '0;
            rob_reg[i] <= '0;
            qj_reg[i]  <= '0;
            qk_reg[i]  <= '0;
         end
      end else if (!rdy_in) begin
         iss_valid_reg <= 1'b0;
      end else if (clear_in) begin
         busy_reg      <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         iss_valid_reg <= 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (wj_a[i]) begin
               vj_reg[i] <= result_a_cdb_in;
               rj_reg[i] <= 1'b0;
            end else if (wj_l[i]) begin
               vj_reg[i] <= result_l_cdb_in;
               rj_reg[i] <= 1'b0;
            end
            if (wk_a[i]) begin
               vk_reg[i] <= result_a_cdb_in;
               rk_reg[i] <= 1'b0;
            end else if (wk_l[i]) begin
               vk_reg[i] <= result_l_cdb_in;
               rk_reg[i] <= 1'b0;
            end
         end
         if (do_dsp) begin
            busy_reg[free_idx] <= 1'b1;
            pc_reg[free_idx]   <= pc_dsp_in;
            op_reg[free_idx]   <= opcode_dsp_in;
            imm_reg[free_idx]  <= imm_dsp_in;
            rob_reg[free_idx]  <= rob_id_dsp_in;
            vj_reg[free_idx]   <= dsp_vj;
            rj_reg[free_idx]   <= dsp_rj;
            qj_reg[free_idx]   <= qj_dsp_in;
            vk_reg[free_idx]   <= dsp_vk;
            rk_reg[free_idx]   <= dsp_rk;
            qk_reg[free_idx]   <= qk_dsp_in;
         end
         if (do_iss) begin
            busy_reg[sel_idx] <= 1'b0;
            iss_valid_reg     <= 1'b1;
            iss_pc_reg        <= pc_reg[sel_idx];
            iss_op_reg        <= op_reg[sel_idx];
            iss_vj_reg        <= vj_reg[sel_idx];
            iss_vk_reg        <= vk_reg[sel_idx];
            iss_imm_reg       <= imm_reg[sel_idx];
            iss_rob_reg       <= rob_reg[sel_idx];
         end else begin
            iss_valid_reg <= 1'b0;
         end
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_W'(RS_SIZE));
      end
   end

   assign full_dsp_out   = full_reg;
   assign rdy_alu_out    = iss_valid_reg;
   assign pc_alu_out     = iss_pc_reg;
   assign opcode_alu_out = iss_op_reg;
   assign vj_alu_out     = iss_vj_reg;
   assign vk_alu_out     = iss_vk_reg;
   assign imm_alu_out    = iss_imm_reg;
   assign rob_id_alu_out = iss_rob_reg;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed scenarios followed by random traffic, every cycle checked against an
// entry-list model of the reservation station.
module tb_alu_reservation_station;
   localparam int N  = 16;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int OW = 6;
   localparam int RW = 4;

   logic          clk, rst_n, rdy, clear, en, qjb, qkb, full;
   logic [AW-1:0] pc_d;
   logic [OW-1:0] op_d;
   logic [DW-1:0] imm_d, vj_d, vk_d;
   logic [RW-1:0] rob_d, qj_d, qk_d;
   logic          cdb_a, cdb_l, idle;
   logic [DW-1:0] res_a, res_l;
   logic [RW-1:0] tag_a, tag_l;
   logic          iss;
   logic [AW-1:0] pc_o;
   logic [OW-1:0] op_o;
   logic [DW-1:0] vj_o, vk_o, imm_o;
   logic [RW-1:0] rob_o;

   alu_reservation_station dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_in(clear), .en_dsp_in(en),
      .pc_dsp_in(pc_d), .opcode_dsp_in(op_d), .imm_dsp_in(imm_d), .rob_id_dsp_in(rob_d),
      .vj_dsp_in(vj_d), .vk_dsp_in(vk_d), .qj_dsp_in(qj_d), .qk_dsp_in(qk_d),
      .qj_busy_dsp_in(qjb), .qk_busy_dsp_in(qkb), .full_dsp_out(full),
      .rdy_a_cdb_in(cdb_a), .result_a_cdb_in(res_a), .rob_id_a_cdb_in(tag_a),
      .rdy_l_cdb_in(cdb_l), .result_l_cdb_in(res_l), .rob_id_l_cdb_in(tag_l),
      .idle_alu_in(idle), .rdy_alu_out(iss), .pc_alu_out(pc_o), .opcode_alu_out(op_o),
      .vj_alu_out(vj_o), .vk_alu_out(vk_o), .imm_alu_out(imm_o), .rob_id_alu_out(rob_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a table of occupied slots plus the expected ALU-side outputs.
   bit            m_busy [N];
   bit            m_pj [N], m_pk [N];
   logic [AW-1:0] m_pc [N];
   logic [OW-1:0] m_op [N];
   logic [DW-1:0] m_imm [N], m_vj [N], m_vk [N];
   logic [RW-1:0] m_rob [N], m_qj [N], m_qk [N];
   bit            m_full, e_rdy;
   logic [AW-1:0] e_pc;
   logic [OW-1:0] e_op;
   logic [DW-1:0] e_vj, e_vk, e_imm;
   logic [RW-1:0] e_rob;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_full = 1'b0; e_rdy = 1'b0;
      e_pc = '0; e_op = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_rob = '0;
   endtask

   // Operand value seen on a bus this cycle, ALU bus first.
   task automatic snoop(input logic [RW-1:0] q, inout bit pend, inout logic [DW-1:0] v);
      if (!pend) return;
      if (cdb_a && tag_a == q) begin v = res_a; pend = 1'b0; end
      else if (cdb_l && tag_l == q) begin v = res_l; pend = 1'b0; end
   endtask

   task automatic model_edge();
      int cand, fr, n;
      if (!rdy) begin e_rdy = 1'b0; return; end
      if (clear) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
         m_full = 1'b0; e_rdy = 1'b0;
         return;
      end
      cand = -1; fr = -1;
      for (int i = 0; i < N; i++) begin
         if (cand < 0 && m_busy[i] && !m_pj[i] && !m_pk[i]) cand = i;
         if (fr < 0 && !m_busy[i]) fr = i;
      end
      for (int i = 0; i < N; i++) begin
         if (m_busy[i]) begin
            snoop(m_qj[i], m_pj[i], m_vj[i]);
            snoop(m_qk[i], m_pk[i], m_vk[i]);
         end
      end
      if (idle && cand >= 0) begin
         e_rdy = 1'b1; e_pc = m_pc[cand]; e_op = m_op[cand]; e_vj = m_vj[cand];
         e_vk = m_vk[cand]; e_imm = m_imm[cand]; e_rob = m_rob[cand];
         m_busy[cand] = 1'b0;
      end else begin
         e_rdy = 1'b0;
      end
      if (en && !m_full && fr >= 0) begin
         m_busy[fr] = 1'b1; m_pc[fr] = pc_d; m_op[fr] = op_d; m_imm[fr] = imm_d;
         m_rob[fr] = rob_d; m_qj[fr] = qj_d; m_qk[fr] = qk_d;
         m_vj[fr] = vj_d; m_pj[fr] = qjb; m_vk[fr] = vk_d; m_pk[fr] = qkb;
         snoop(qj_d, m_pj[fr], m_vj[fr]);
         snoop(qk_d, m_pk[fr], m_vk[fr]);
      end
      n = 0;
      for (int i = 0; i < N; i++) if (m_busy[i]) n++;
      m_full = (n == N);
   endtask

   task automatic compare_all();
      chk("rdy_alu_out", 64'(iss), 64'(e_rdy));
      chk("full_dsp_out", 64'(full), 64'(m_full));
      chk("pc_alu_out", 64'(pc_o), 64'(e_pc));
      chk("opcode_alu_out", 64'(op_o), 64'(e_op));
      chk("vj_alu_out", 64'(vj_o), 64'(e_vj));
      chk("vk_alu_out", 64'(vk_o), 64'(e_vk));
      chk("imm_alu_out", 64'(imm_o), 64'(e_imm));
      chk("rob_id_alu_out", 64'(rob_o), 64'(e_rob));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      if (iss) $display("issue rob=%0d pc=%h op=%0d vj=%h vk=%h imm=%h", rob_o, pc_o, op_o, vj_o, vk_o, imm_o);
   endtask

   task automatic dsp(input logic [AW-1:0] pc, input logic [OW-1:0] op, input logic [DW-1:0] imm,
                      input logic [RW-1:0] rob, input logic [DW-1:0] vj, input logic [RW-1:0] qj,
                      input logic pj, input logic [DW-1:0] vk, input logic [RW-1:0] qk, input logic pk);
      en = 1'b1; pc_d = pc; op_d = op; imm_d = imm; rob_d = rob;
      vj_d = vj; qj_d = qj; qjb = pj; vk_d = vk; qk_d = qk; qkb = pk;
   endtask

   initial begin
      rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; idle = 1'b1;
      en = 1'b0; pc_d = '0; op_d = '0; imm_d = '0; rob_d = '0;
      vj_d = '0; vk_d = '0; qj_d = '0; qk_d = '0; qjb = 1'b0; qkb = 1'b0;
      cdb_a = 1'b0; cdb_l = 1'b0; res_a = '0; res_l = '0; tag_a = '0; tag_l = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Both operands ready: issues one edge after dispatch
      dsp(32'h100, 6'd1, 32'd0, 4'd3, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0);
      step(); en = 1'b0;
      chk("add_not_same_edge", 64'(iss), 64'd0);
      step();
      chk("add_issue", 64'(iss), 64'd1);
      chk("add_vj", 64'(vj_o), 64'd5);
      chk("add_vk", 64'(vk_o), 64'd7);
      chk("add_rob", 64'(rob_o), 64'd3);
      step();
      chk("add_one_cycle", 64'(iss), 64'd0);

      // Pending operand woken by the ALU bus two cycles after dispatch
      dsp(32'h104, 6'd2, 32'd8, 4'd4, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 1'b0);
      step(); en = 1'b0;
      step();
      cdb_a = 1'b1; tag_a = 4'd2; res_a = 32'h10;
      step(); cdb_a = 1'b0;
      chk("addi_wait", 64'(iss), 64'd0);
      step();
      chk("addi_issue", 64'(iss), 64'd1);
      chk("addi_vj", 64'(vj_o), 64'h10);

      // Broadcast coincident with dispatch is captured on the way in
      dsp(32'h108, 6'd3, 32'd0, 4'd5, 32'd0, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0);
      cdb_l = 1'b1; tag_l = 4'd4; res_l = 32'd9;
      step(); en = 1'b0; cdb_l = 1'b0;
      step();
      chk("coinc_issue", 64'(iss), 64'd1);
      chk("coinc_vj", 64'(vj_o), 64'd9);

      // Asynchronous reset between edges with three stalled entries
      for (int i = 0; i < 3; i++) begin
         dsp(32'h180 + 32'(i * 4), 6'd5, 32'd0, 4'(i), 32'd0, 4'hE, 1'b1, 32'd0, 4'd0, 1'b0);
         step();
      end
      en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_rdy", 64'(iss), 64'd0);
      chk("async_rst_vj", 64'(vj_o), 64'd0);
      chk("async_rst_full", 64'(full), 64'd0);
      compare_all();
      #2 rst_n = 1'b1;

      // Fill every slot with stalled ops, then free one by waking slot 5
      for (int i = 0; i < N; i++) begin
         dsp(32'h200 + 32'(i * 4), 6'd4, 32'(i), 4'(i), 32'(i), 4'(i), 1'b1, 32'h100 + 32'(i), 4'd0, 1'b0);
         step();
      end
      chk("full_set", 64'(full), 64'd1);
      dsp(32'hDEAD, 6'd7, 32'd0, 4'd0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0, 1'b0);
      step(); en = 1'b0;
      chk("full_hold", 64'(full), 64'd1);
      cdb_a = 1'b1; tag_a = 4'd5; res_a = 32'h55;
      step(); cdb_a = 1'b0;
      step();
      chk("wake5_issue", 64'(iss), 64'd1);
      chk("wake5_pc", 64'(pc_o), 64'h214);
      chk("wake5_vj", 64'(vj_o), 64'h55);
      chk("full_drop", 64'(full), 64'd0);

      // Flush with eight busy (one ready) while the ALU becomes idle
      clear = 1'b1; step(); clear = 1'b0;
      idle = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dsp(32'h280 + 32'(i * 4), 6'd6, 32'd0, 4'(i), 32'd1, 4'hF, (i != 3), 32'd2, 4'd0, 1'b0);
         step();
      end
      en = 1'b0; idle = 1'b1; clear = 1'b1;
      step(); clear = 1'b0;
      chk("clear_no_issue", 64'(iss), 64'd0);
      idle = 1'b0;
      dsp(32'h300, 6'd8, 32'd0, 4'd9, 32'd3, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0);
      step();
      dsp(32'h304, 6'd8, 32'd0, 4'd10, 32'd3, 4'd0, 1'b0, 32'd4, 4'd0, 1'b0);
      step(); en = 1'b0; idle = 1'b1;
      step();
      chk("post_clear_first", 64'(pc_o), 64'h300);
      step();

      // Stalled pipeline: nothing moves while rdy_in is low
      rdy = 1'b0;
      dsp(32'h400, 6'd9, 32'd0, 4'd1, 32'd1, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0);
      step(); step(); en = 1'b0;
      chk("stall_no_issue", 64'(iss), 64'd0);
      rdy = 1'b1;
      step(); step();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rdy   = ($urandom_range(0, 9) != 0);
         clear = ($urandom_range(0, 59) == 0);
         idle  = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         en    = ($urandom_range(0, 2) != 0);
         pc_d  = $urandom; op_d = 6'($urandom); imm_d = $urandom; rob_d = 4'($urandom);
         vj_d  = $urandom; vk_d = $urandom;
         qj_d  = 4'($urandom); qk_d = 4'($urandom);
         qjb   = 1'($urandom); qkb = 1'($urandom);
         cdb_a = 1'($urandom); tag_a = 4'($urandom); res_a = $urandom;
         cdb_l = 1'($urandom); tag_l = 4'($urandom); res_l = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
